sub_operand_loader: RTL and testbench
=====================================

# sub_operand_loader

Sequential operand front end for the 4-bit two's complement subtractor. It takes one shared switch bus plus a load pushbutton, captures operand A on the first debounced press and operand B on the second, and then presents both to the subtractor with a valid flag. It sits directly upstream of the subtractor's A/B inputs and releases the operands when the consumer acknowledges them.

## Interface
- WIDTH, 4, operand width; matches the subtractor's A/B width.
- DEBOUNCE_CYCLES, 4, number of consecutive synchronized cycles a button level must hold before it is accepted; must be ≥1.

- clk  in  1  single system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- sw_in  in  WIDTH  raw switch bus; operand value.
- load_btn  in  1  raw load pushbutton, active-high, asynchronous to clk.
- clear_btn  in  1  raw clear pushbutton, active-high, asynchronous to clk.
- op_ack  in  1  consumer acknowledge; synchronous to clk.
- A  out  WIDTH  registered minuend to the subtractor.
- B  out  WIDTH  registered subtrahend to the subtractor.
- operands_valid  out  1  high while A and B are a complete pair.
- state_o  out  2  FSM state for LEDs: 00 IDLE, 01 GOT_A, 10 READY.

## Operation
- Synchronizers: sw_in, load_btn and clear_btn each pass through a 2-flop synchronizer. All logic uses only the synchronized copies (sw_s, ld_s, clr_s).
- Load debounce: debounced level db and counter cnt, width $clog2(DEBOUNCE_CYCLES+1). Each edge applies the first matching rule:
  - if ld_s==db, then cnt<=0;
  - if cnt==DEBOUNCE_CYCLES-1, then db<=ld_s and cnt<=0;
  - otherwise cnt<=cnt+1.
- Load pulse: ld_pulse = db & ~db_q, where db_q is db delayed one cycle. It is high for exactly one cycle per accepted press. A release must also pass debounce before another press is accepted.
- clr_s is level-sensitive and not debounced.
- FSM, evaluated in priority order rst > clr_s > ld_pulse > op_ack:
  - IDLE: ld_pulse → A<=sw_s, go to GOT_A.
  - GOT_A: ld_pulse → B<=sw_s, go to READY.
  - READY: operands_valid=1. op_ack → IDLE, with A and B held. ld_pulse → A<=sw_s, go to GOT_A, with B held and valid dropping.
  - op_ack outside READY is ignored.
  - ld_pulse and op_ack in the same READY cycle: ld_pulse wins.
  - clr_s high in any state: A<=0, B<=0, go to IDLE. This is held for every cycle clr_s stays high, and load pulses during that time are discarded.
- Arithmetic: none. A and B are raw unsigned WIDTH-bit copies of sw_s, and the downstream stage interprets them. No truncation or extension is applied.
- Debounce state is independent of the FSM. clr_s does not reset db or cnt.

## Timing
- Reset, effective at the next edge: all synchronizer flops 0, db=0, db_q=0, cnt=0, A=0, B=0, operands_valid=0, state_o=00.
  - rst mid-press: the press is lost. The button must be seen low-to-high again after the debounced level has returned low.
- Press latency: load_btn high and stable, first sampled at edge k. Then ld_s=1 after edge k+1, db=1 after edge k+DEBOUNCE_CYCLES+1, and A or B updates at edge k+DEBOUNCE_CYCLES+2. With DEBOUNCE_CYCLES=4, that is edge k+6.
- sw_in must be stable from edge k-2 through the capture edge.
- Glitch rejection: a synchronized high run shorter than DEBOUNCE_CYCLES cycles never changes db and never produces a pulse.
- operands_valid and state_o are registered and change on the same edge as the FSM transition.
  - operands_valid rises on the edge that captures B.
  - operands_valid falls on the edge that samples op_ack=1, a clear, or a new load.
- Clear latency: clear_btn high sampled at edge k takes effect at edge k+2 (two synchronizer stages, then the register update).

## Test plan
- Reset: hold rst for 2 cycles with load_btn high → A=0000, B=0000, operands_valid=0, state_o=00. No pulse until db passes debounce after rst is released.
- Normal pair (DEBOUNCE_CYCLES=4), including latency:
  - sw_in=0111, load_btn high for 8 cycles then low for 8 → A=0111 at edge k+6, state_o=01.
  - sw_in=0101, press again → B=0101, operands_valid=1, state_o=10.
  - Downstream subtractor shows Sum=0010, Cout=1.
- Bounce: load_btn pattern high 3, low 2, high 2, low 10 → no capture; A, B and state_o unchanged.
- Acknowledge: in READY with A=0110, B=0111, pulse op_ack for 1 cycle → next edge operands_valid=0, state_o=00, A=0110, B=0111 held. An op_ack pulse in IDLE has no effect.
- Clear priority: in GOT_A, assert clear_btn so clr_s is high in the same cycle as ld_pulse → A=0000, B=0000, state_o=00, and B is not captured.
- Reload from READY: READY with A=1000, B=1000, then press load with sw_in=0001 → A=0001, B=1000, operands_valid=0, state_o=01.

Source files
------------

// File: rtl/sub_operand_loader.sv
// Sequential operand front end for the 4-bit subtractor: synchronizes the switch bus and
// buttons, debounces the load button, and captures A then B on successive presses.
module sub_operand_loader #(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_in,
    input  logic             load_btn,
    input  logic             clear_btn,
    input  logic             op_ack,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic             operands_valid,
    output logic [1:0]       state_o
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GOT_A = 2'b01,
        READY = 2'b10
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   a_nxt;
    logic [WIDTH-1:0]   b_nxt;
    logic               valid_nxt;

    logic [WIDTH-1:0]   sw_m;
    logic [WIDTH-1:0]   sw_s;
    logic               ld_m;
    logic               ld_s;
    logic               clr_m;
    logic               clr_s;

    logic               db;
    logic               db_q;
    logic [CNT_W-1:0]   cnt;
    logic               ld_pulse;

    // Two-flop synchronizers for everything arriving from the board.
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_m  <= '0;
            sw_s  <= '0;
            ld_m  <= 1'b0;
            ld_s  <= 1'b0;
            clr_m <= 1'b0;
            clr_s <= 1'b0;
        end else begin
            sw_m  <= sw_in;
            sw_s  <= sw_m;
            ld_m  <= load_btn;
            ld_s  <= ld_m;
            clr_m <= clear_btn;
            clr_s <= clr_m;
        end
    end

    // Load debounce: a new level must hold DEBOUNCE_CYCLES cycles; clear does not touch it.
    always_ff @(posedge clk) begin
        if (rst) begin
            db   <= 1'b0;
            db_q <= 1'b0;
            cnt  <= '0;
        end else begin
            db_q <= db;
            if (ld_s == db) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                db  <= ld_s;
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign ld_pulse = db & ~db_q;

    // FSM and operand registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            A              <= '0;
            B              <= '0;
            operands_valid <= 1'b0;
        end else begin
            state          <= state_nxt;
            A              <= a_nxt;
            B              <= b_nxt;
            operands_valid <= valid_nxt;
        end
    end

    // Next state: clear beats load, load beats acknowledge.
    always_comb begin
        state_nxt = state;
        a_nxt     = A;
        b_nxt     = B;
        if (clr_s) begin
            state_nxt = IDLE;
            a_nxt     = '0;
            b_nxt     = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ld_pulse) begin
                        a_nxt     = sw_s;
                        state_nxt = GOT_A;
                    end
                end
                GOT_A: begin
                    if (ld_pulse) begin
                        b_nxt     = sw_s;
                        state_nxt = READY;
                    end
                end
                READY: begin
                    if (ld_pulse) begin
                        a_nxt     = sw_s;
                        state_nxt = GOT_A;
                    end else if (op_ack) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
        valid_nxt = (state_nxt == READY);
    end

    assign state_o = state;

endmodule

// File: tb/tb_sub_operand_loader.sv
// Directed bench for sub_operand_loader with hand-computed expectations (DEBOUNCE_CYCLES=4).
module tb_sub_operand_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] sw_in;
    logic       load_btn;
    logic       clear_btn;
    logic       op_ack;
    logic [3:0] A;
    logic [3:0] B;
    logic       operands_valid;
    logic [1:0] state_o;

    int cmp_cnt = 0;
    int err_cnt = 0;

    sub_operand_loader #(.WIDTH(4), .DEBOUNCE_CYCLES(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .sw_in          (sw_in),
        .load_btn       (load_btn),
        .clear_btn      (clear_btn),
        .op_ack         (op_ack),
        .A              (A),
        .B              (B),
        .operands_valid (operands_valid),
        .state_o        (state_o)
    );

    always #5 clk = ~clk;

    // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Full press: switches settle, button held hi cycles, released lo cycles.
    task automatic press(input logic [3:0] v, input int hi, input int lo);
        sw_in = v;
        tick(2);
        load_btn = 1'b1;
        tick(hi);
        load_btn = 1'b0;
        tick(lo);
    endtask

    task automatic do_clear();
        clear_btn = 1'b1;
        tick(1);
        clear_btn = 1'b0;
        tick(3);
    endtask

    task automatic test_reset();
        rst = 1'b1; sw_in = 4'b1010; load_btn = 1'b1; clear_btn = 1'b0; op_ack = 1'b0;
        tick(2);
        cmp_cnt++; if (A !== 4'b0000) begin err_cnt++; $display("FAIL reset_A got=%b exp=0000", A); end
        cmp_cnt++; if (B !== 4'b0000) begin err_cnt++; $display("FAIL reset_B got=%b exp=0000", B); end
        cmp_cnt++; if (operands_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_valid got=%b exp=0", operands_valid); end
        cmp_cnt++; if (state_o !== 2'b00) begin err_cnt++; $display("FAIL reset_state got=%b exp=00", state_o); end
        rst = 1'b0;
        // Button still high: sampled at the first edge after reset, captured six edges later.
        tick(6);
        cmp_cnt++; if (state_o !== 2'b00) begin err_cnt++; $display("FAIL reset_no_early_pulse state got=%b exp=00", state_o); end
        tick(1);
        cmp_cnt++; if (state_o !== 2'b01 || A !== 4'b1010) begin err_cnt++; $display("FAIL reset_post_capture state=%b A=%b exp 01/1010", state_o, A); end
        load_btn = 1'b0;
        tick(8);
        do_clear();
        cmp_cnt++; if (state_o !== 2'b00 || A !== 4'b0000) begin err_cnt++; $display("FAIL reset_cleanup state=%b A=%b exp 00/0000", state_o, A); end
    endtask

    task automatic test_normal_pair();
        logic [4:0] diff;
        sw_in = 4'b0111;
        tick(2);
        load_btn = 1'b1;
        tick(6);  // now just after edge k+5
        cmp_cnt++; if (state_o !== 2'b00 || A !== 4'b0000) begin err_cnt++; $display("FAIL latency_k5 state=%b A=%b exp 00/0000", state_o, A); end
        tick(1);  // edge k+6
        cmp_cnt++; if (state_o !== 2'b01 || A !== 4'b0111) begin err_cnt++; $display("FAIL latency_k6 state=%b A=%b exp 01/0111", state_o, A); end
        cmp_cnt++; if (operands_valid !== 1'b0) begin err_cnt++; $display("FAIL got_a_valid got=%b exp=0", operands_valid); end
        tick(1);
        load_btn = 1'b0;
        tick(8);
        press(4'b0101, 8, 8);
        cmp_cnt++; if (B !== 4'b0101 || A !== 4'b0111) begin err_cnt++; $display("FAIL pair_AB A=%b B=%b exp 0111/0101", A, B); end
        cmp_cnt++; if (operands_valid !== 1'b1 || state_o !== 2'b10) begin err_cnt++; $display("FAIL pair_ready valid=%b state=%b exp 1/10", operands_valid, state_o); end
        diff = {1'b0, A} + {1'b0, ~B} + 5'd1;
        cmp_cnt++; if (diff !== 5'b10010) begin err_cnt++; $display("FAIL pair_subtract cout_sum=%b exp=1_0010", diff); end
    endtask

    task automatic test_bounce();
        sw_in = 4'b1111;
        tick(2);
        load_btn = 1'b1; tick(3);
        load_btn = 1'b0; tick(2);
        load_btn = 1'b1; tick(2);
        load_btn = 1'b0; tick(10);
        cmp_cnt++; if (A !== 4'b0111 || B !== 4'b0101) begin err_cnt++; $display("FAIL bounce_AB A=%b B=%b exp 0111/0101", A, B); end
        cmp_cnt++; if (state_o !== 2'b10 || operands_valid !== 1'b1) begin err_cnt++; $display("FAIL bounce_state state=%b valid=%b exp 10/1", state_o, operands_valid); end
    endtask

    task automatic test_ack();
        do_clear();
        press(4'b0110, 8, 8);
        press(4'b0111, 8, 8);
        cmp_cnt++; if (state_o !== 2'b10) begin err_cnt++; $display("FAIL ack_setup state=%b exp=10", state_o); end
        op_ack = 1'b1;
        tick(1);
        op_ack = 1'b0;
        cmp_cnt++; if (operands_valid !== 1'b0 || state_o !== 2'b00) begin err_cnt++; $display("FAIL ack_release valid=%b state=%b exp 0/00", operands_valid, state_o); end
        cmp_cnt++; if (A !== 4'b0110 || B !== 4'b0111) begin err_cnt++; $display("FAIL ack_hold A=%b B=%b exp 0110/0111", A, B); end
        op_ack = 1'b1;
        tick(1);
        op_ack = 1'b0;
        tick(1);
        cmp_cnt++; if (state_o !== 2'b00 || operands_valid !== 1'b0 || A !== 4'b0110) begin err_cnt++; $display("FAIL ack_idle state=%b valid=%b A=%b exp 00/0/0110", state_o, operands_valid, A); end
    endtask

    task automatic test_reload();
        press(4'b1000, 8, 8);
        press(4'b1000, 8, 8);
        cmp_cnt++; if (state_o !== 2'b10 || A !== 4'b1000 || B !== 4'b1000) begin err_cnt++; $display("FAIL reload_setup state=%b A=%b B=%b exp 10/1000/1000", state_o, A, B); end
        press(4'b0001, 8, 8);
        cmp_cnt++; if (A !== 4'b0001 || B !== 4'b1000) begin err_cnt++; $display("FAIL reload_AB A=%b B=%b exp 0001/1000", A, B); end
        cmp_cnt++; if (operands_valid !== 1'b0 || state_o !== 2'b01) begin err_cnt++; $display("FAIL reload_state valid=%b state=%b exp 0/01", operands_valid, state_o); end
    endtask

    task automatic test_clear_priority();
        // Starts in GOT_A; clear reaches clr_s in the same cycle ld_pulse is high.
        sw_in = 4'b0011;
        tick(2);
        load_btn = 1'b1;
        tick(4);          // after edge k+3
        clear_btn = 1'b1; // sampled at k+4, effective at k+6
        tick(2);          // after edge k+5
        cmp_cnt++; if (state_o !== 2'b01 || A !== 4'b0001) begin err_cnt++; $display("FAIL clear_pre state=%b A=%b exp 01/0001", state_o, A); end
        tick(1);          // edge k+6
        cmp_cnt++; if (A !== 4'b0000 || B !== 4'b0000 || state_o !== 2'b00) begin err_cnt++; $display("FAIL clear_prio A=%b B=%b state=%b exp 0000/0000/00", A, B, state_o); end
        tick(2);
        load_btn = 1'b0;
        clear_btn = 1'b0;
        tick(10);
        cmp_cnt++; if (state_o !== 2'b00 || B !== 4'b0000 || A !== 4'b0000) begin err_cnt++; $display("FAIL clear_discard state=%b A=%b B=%b exp 00/0000/0000", state_o, A, B); end
    endtask

    initial begin
        test_reset();
        test_normal_pair();
        test_bounce();
        test_ack();
        test_reload();
        test_clear_priority();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
